// File: rtl/pad_frame_decoder_if.sv
// rtl/pad_frame_decoder_if.sv - byte input and decoded pad outputs of the remote pad frame decoder
interface pad_frame_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [9:0] y_pad_uart;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       link_up;

    modport master (
        output rx_data, rx_done,
        input  y_pad_uart, frame_valid, frame_err, err_cnt, link_up
    );

    modport slave (
        input  rx_data, rx_done,
        output y_pad_uart, frame_valid, frame_err, err_cnt, link_up
    );
endinterface

// File: rtl/pad_frame_decoder.sv
// rtl/pad_frame_decoder.sv - validates 4-byte UART pad frames and holds the last good remote pad position
module pad_frame_decoder #(
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         Y_RESET      = 312,
    parameter int         Y_MAX        = 623,
    parameter int         BYTE_TIMEOUT = 100000,
    parameter int         LINK_TIMEOUT = 6500000
) (
    input  logic                 clk,
    input  logic                 rst,
    pad_frame_decoder_if.slave   bus
);
    localparam int TO_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, WAIT_CHK} state_t;

    state_t            state, state_n;
    logic [1:0]        hi_q;
    logic [7:0]        lo_q;
    logic [TO_W-1:0]   to_cnt;
    logic [LINK_W-1:0] link_cnt, link_cnt_n;
    logic [9:0]        y_q;
    logic              frame_valid_q, frame_err_q, link_up_q;
    logic [7:0]        err_cnt_q;

    logic              accept, err, latch_hi, latch_lo, timeout;
    logic [9:0]        y_new;
    logic [7:0]        chk_exp;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        err      = 1'b0;
        latch_hi = 1'b0;
        latch_lo = 1'b0;
        y_new    = {hi_q, lo_q};
        chk_exp  = HEADER ^ {6'b0, hi_q} ^ lo_q;
        timeout  = (state != IDLE) && (to_cnt == TO_W'(BYTE_TIMEOUT - 1));

        // A byte arriving in the expiry cycle wins over the timeout.
        if (bus.rx_done) begin
            case (state)
                IDLE: begin
                    if (bus.rx_data == HEADER) state_n = WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.rx_data == HEADER) begin
                        state_n = WAIT_HI;
                    end else if (bus.rx_data[7:2] != 6'b0) begin
                        state_n = IDLE;
                        err     = 1'b1;
                    end else begin
                        latch_hi = 1'b1;
                        state_n  = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    latch_lo = 1'b1;
                    state_n  = WAIT_CHK;
                end
                WAIT_CHK: begin
                    state_n = IDLE;
                    if (bus.rx_data != chk_exp || y_new > 10'(Y_MAX)) err = 1'b1;
                    else                                                accept = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
        end

        if (accept)                                   link_cnt_n = '0;
        else if (link_cnt == LINK_W'(LINK_TIMEOUT))   link_cnt_n = link_cnt;
        else                                          link_cnt_n = link_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hi_q          <= '0;
            lo_q          <= '0;
            to_cnt        <= '0;
            link_cnt      <= LINK_W'(LINK_TIMEOUT);
            y_q           <= 10'(Y_RESET);
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
            link_up_q     <= 1'b0;
        end else begin
            state         <= state_n;
            if (latch_hi) hi_q <= bus.rx_data[1:0];
            if (latch_lo) lo_q <= bus.rx_data;
            to_cnt        <= (bus.rx_done || state_n == IDLE) ? '0 : to_cnt + 1'b1;
            link_cnt      <= link_cnt_n;
            link_up_q     <= (link_cnt_n < LINK_W'(LINK_TIMEOUT));
            frame_valid_q <= accept;
            frame_err_q   <= err;
            if (accept) y_q <= y_new;
            if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.y_pad_uart  = y_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.link_up     = link_up_q;
endmodule

// File: tb/tb_pad_frame_decoder.sv
// tb/tb_pad_frame_decoder.sv - table-driven scoreboard bench for pad_frame_decoder
module tb_pad_frame_decoder;
    localparam int BT = 16;
    localparam int LT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pad_frame_decoder_if ifc ();

    pad_frame_decoder #(
        .HEADER(8'hA5), .Y_RESET(312), .Y_MAX(623),
        .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic       v;
        logic       e;
        logic [9:0] y;
        int         due;
    } exp_t;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic        v;
        logic [9:0]  y;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int y_model = 312;
    int err_model = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and score any output event against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ifc.frame_valid === 1'b1 || ifc.frame_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {ifc.frame_valid, ifc.frame_err}, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {ifc.frame_valid, ifc.frame_err}, {e.v, e.e});
                if (e.due >= 0) check("event_latency", cyc, e.due);
                if (e.v) begin
                    check("accept_y", ifc.y_pad_uart, e.y);
                    check("link_up_on_accept", ifc.link_up, 1);
                    last_valid_cyc = cyc;
                end else begin
                    last_err_cyc = cyc;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.rx_data = b;
        ifc.rx_done = 1'b1;
        tick();
        ifc.rx_done = 1'b0;
    endtask

    task automatic send_vec(input vec_t vt, input int gap);
        exp_t e;
        for (int k = 0; k < vt.n; k++) begin
            if (k == vt.n - 1) begin
                e.v = vt.v; e.e = !vt.v; e.y = vt.y; e.due = cyc + 1;
                sb.push_back(e);
            end
            send_byte(vt.bytes[47-8*k -: 8]);
            if (k != vt.n - 1) repeat (gap) tick();
        end
        if (vt.v) y_model = vt.y;
        else if (err_model < 255) err_model++;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pending"}, sb.size(), 0);
        check({tag, "_y"}, ifc.y_pad_uart, y_model);
        check({tag, "_err_cnt"}, ifc.err_cnt, err_model);
    endtask

    task automatic check_reset_values();
        check("rst_y", ifc.y_pad_uart, 312);
        check("rst_valid", ifc.frame_valid, 0);
        check("rst_err", ifc.frame_err, 0);
        check("rst_err_cnt", ifc.err_cnt, 0);
        check("rst_link_up", ifc.link_up, 0);
    endtask

    initial begin
        exp_t e;
        int   a0;
        vecs[0] = '{48'hA5_01_90_34_0000, 4, 1'b1, 10'd400};
        vecs[1] = '{48'hA5_01_90_35_0000, 4, 1'b0, 10'd0};
        vecs[2] = '{48'hA5_02_BC_1B_0000, 4, 1'b0, 10'd0};
        vecs[3] = '{48'hA5_04_000000_00, 2, 1'b0, 10'd0};
        vecs[4] = '{48'h00_A5_A5_00_00_A5, 6, 1'b1, 10'd0};
        vecs[5] = '{48'hA5_00_A5_00_0000, 4, 1'b1, 10'd165};
        vecs[6] = '{48'hA5_02_6F_C8_0000, 4, 1'b1, 10'd623};
        vecs[7] = '{48'hA5_02_70_D7_0000, 4, 1'b0, 10'd0};

        rst = 1'b1;
        ifc.rx_data = 8'h00;
        ifc.rx_done = 1'b0;
        repeat (3) tick();
        check_reset_values();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            send_vec(vecs[i], 0);
            repeat (2) tick();
            check_state($sformatf("vec%0d", i));
        end

        // Back-to-back frames, header right after checksum.
        send_vec(vecs[0], 0);
        send_vec(vecs[5], 0);
        send_vec(vecs[6], 0);
        repeat (2) tick();
        check_state("b2b");

        // Byte timeout after a lone header.
        send_byte(8'hA5);
        a0 = cyc;
        e.v = 1'b0; e.e = 1'b1; e.y = '0; e.due = -1;
        sb.push_back(e);
        err_model++;
        repeat (BT + 8) tick();
        check("timeout_latency_ok", ((last_err_cyc - a0) >= BT - 1) && ((last_err_cyc - a0) <= BT + 2), 1);
        check_state("timeout");

        // Slow but in-time bytes, then link drop after the accept.
        send_vec(vecs[0], BT - 4);
        repeat (2) tick();
        check_state("slow_frame");
        while (cyc < last_valid_cyc + LT - 1) tick();
        check("link_up_before_drop", ifc.link_up, 1);
        tick();
        check("link_up_after_drop", ifc.link_up, 0);

        // Reset in the middle of a frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values();
        y_model = 312;
        err_model = 0;
        tick();
        send_vec(vecs[0], 0);
        repeat (2) tick();
        check_state("after_mid_reset");

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send_vec(vecs[3], 0);
        repeat (2) tick();
        check("err_cnt_saturated", ifc.err_cnt, 255);
        check_state("saturation");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pad_frame_decoder.md
# pad_frame_decoder

Decodes the byte stream from the board-to-board UART receiver into the remote player's 10-bit pad position. It validates framing, checksum and range, then holds the last good position on `y_pad_uart` for player 2's pad controller, which uses it when manual control is off. It also reports link health and frame errors.

## Interface
- `HEADER`, 8'hA5: frame start byte.
- `Y_RESET`, 312: `y_pad_uart` value after reset (centred pad).
- `Y_MAX`, 623: largest accepted position (768 lines − 145-line pad).
- `BYTE_TIMEOUT`, 100000: maximum clk cycles allowed between bytes inside a frame.
- `LINK_TIMEOUT`, 6500000: clk cycles without a valid frame before the link is declared down.

- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_data`, in, 8: received byte; sampled only when `rx_done`=1.
- `rx_done`, in, 1: one-cycle strobe, one byte per strobe.
- `y_pad_uart`, out, 10: last accepted remote pad top position.
- `frame_valid`, out, 1: one-cycle pulse when `y_pad_uart` takes a new value.
- `frame_err`, out, 1: one-cycle pulse for each rejected or aborted frame.
- `err_cnt`, out, 8: saturating count of `frame_err` pulses.
- `link_up`, out, 1: a valid frame was accepted within the last `LINK_TIMEOUT` cycles.

## Operation
- Frame format, 4 bytes: `HEADER`, HI, LO, CHK.
  - HI[1:0] = y[9:8]; HI[7:2] must be 0.
  - LO = y[7:0].
  - CHK = `HEADER` ^ HI ^ LO.
- FSM states: IDLE, WAIT_HI, WAIT_LO, WAIT_CHK. Transitions happen only on `rx_done`, except the timeout.
  - IDLE: byte == `HEADER` → WAIT_HI. Any other byte → IDLE, silently, with no error.
  - WAIT_HI:
    - byte == `HEADER` → stay in WAIT_HI (resync, no error).
    - HI[7:2] ≠ 0 → IDLE with error.
    - otherwise latch HI → WAIT_LO.
  - WAIT_LO: latch LO, any value including `HEADER` → WAIT_CHK.
  - WAIT_CHK:
    - CHK mismatch → IDLE with error.
    - match and y > `Y_MAX` → IDLE with error.
    - match and y ≤ `Y_MAX` → accept the frame, IDLE.
- Accepting a frame: `y_pad_uart` ← {HI[1:0], LO}, `frame_valid` pulses, the link counter clears.
- Byte timeout counter:
  - Clears on every `rx_done`.
  - Increments each cycle while not in IDLE.
  - On reaching `BYTE_TIMEOUT` → IDLE with error.
- Simultaneous `rx_done` and timeout expiry: the byte is processed and the timeout is ignored.
- Error: `frame_err` pulses and `err_cnt` increments, saturating at 255. `y_pad_uart` is unchanged on any error.
- Link counter:
  - Saturating; width ≥ clog2(`LINK_TIMEOUT`+1).
  - Increments every cycle and clears on accept.
  - `link_up` = (counter < `LINK_TIMEOUT`).

## Timing
- Reset values: `y_pad_uart`=`Y_RESET`, `frame_valid`=0, `frame_err`=0, `err_cnt`=0, `link_up`=0, link counter=`LINK_TIMEOUT`, FSM=IDLE, timeout counter=0.
- Reset mid-frame discards the partial frame and produces no error pulse.
- Latency: `y_pad_uart` and `frame_valid` update on the clk edge after the cycle in which CHK's `rx_done` is high (1 cycle). `frame_err` follows the same 1-cycle latency after the offending byte or timeout cycle.
- `link_up` rises in the same cycle `frame_valid` is high.
- `link_up` falls exactly `LINK_TIMEOUT` cycles after the last `frame_valid`.
- Back-to-back frames are supported; HEADER may arrive in the cycle after CHK.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench overrides: `BYTE_TIMEOUT`=16, `LINK_TIMEOUT`=64.
- Valid frame: after reset, send A5, 01, 90, 34 → one cycle after CHK, `y_pad_uart`=400, one `frame_valid` pulse, `link_up`=1; `err_cnt`=0.
- Bad checksum: send A5, 01, 90, 35 → `frame_err` pulse, `err_cnt`=1, `y_pad_uart` stays 400.
- Range error: send A5, 02, BC, 1B (y=700, correct CHK) → `frame_err` pulse, `y_pad_uart` unchanged. Bad HI: send A5, 04 → error after the HI byte.
- Resync and noise:
  - Send 00, A5, A5, 00, 00, A5 → accepted, `y_pad_uart`=0, `err_cnt` unchanged.
  - Send A5, 00, A5, 00 (LO=A5, CHK=00) → accepted, `y_pad_uart`=165.
- Timeout: send A5, then wait 16 cycles → `frame_err` pulse, FSM back in IDLE. Then send a full valid frame → accepted. With no further frames, `link_up` drops 64 cycles after that accept.
- Reset mid-frame: send A5, 01, assert `rst` for one cycle → all outputs at reset values, no `frame_err`. A following valid frame is accepted normally.
